data_buf_seq: RTL and testbench

//  Sequencer for the bMAC_SIMD row buffer (data_buf): loads one tile of ROWS rows from an upstream

---
 rtl/bmac_buf_pkg.sv | 25 ++
 rtl/data_buf.sv | 37 +++
 rtl/row_ptr_cnt.sv | 39 +++
 rtl/data_buf_seq.sv | 137 +++++++++++++
 tb/tb_data_buf_seq.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bmac_buf_pkg.sv
// Shared state type and sizing helpers for the bMAC_SIMD row-buffer sequencer.
// MAC_BW / ROW_CNT normally come from param_def.sv; the fallbacks below keep standalone builds complete.
`ifndef MAC_BW
`define MAC_BW 16
`endif
`ifndef ROW_CNT
`define ROW_CNT 4
`endif

package bmac_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } buf_seq_state_t;

  localparam int REP_W = 4;

  // A one-row tile is meaningless; still give it a 1-bit address rather than a zero-width one.
  function automatic int calc_aw(input int rows);
    return (rows < 2) ? 1 : $clog2(rows);
  endfunction

endpackage

// File: rtl/data_buf.sv
// Row buffer: one register per row, cleared by reset, combinational read gated by rd_en.
module data_buf #(
  parameter int ROWS   = 4,
  parameter int MAC_BW = 16,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [MAC_BW-1:0] iData,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [MAC_BW-1:0] oData
);

  logic [MAC_BW-1:0] row_q [ROWS];

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      logic [MAC_BW-1:0] row_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          row_reg <= '0;
        end else if (wr_en && (wr_addr == AW'(gi))) begin
          row_reg <= iData;
        end
      end

      assign row_q[gi] = row_reg;
    end
  endgenerate

  assign oData = rd_en ? row_q[rd_addr] : '0;

endmodule

// File: rtl/row_ptr_cnt.sv
// Row pointer with explicit wrap at MAX, so tiles need not be a power of two rows deep.
module row_ptr_cnt #(
  parameter int MAX = 3,
  parameter int AW  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [AW-1:0] ptr,
  output logic          last
);

  localparam logic [AW-1:0] MAX_P = AW'(MAX);

  logic [AW-1:0] ptr_reg;
  logic [AW-1:0] ptr_next;

  assign last = (ptr_reg == MAX_P);
  assign ptr  = ptr_reg;

  always_comb begin
    ptr_next = ptr_reg;
    if (clr) begin
      ptr_next = '0;
    end else if (inc) begin
      ptr_next = last ? '0 : ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/data_buf_seq.sv
// Fill/drain sequencer for the data_buf row buffer: loads a tile of ROWS rows, then streams them out.
// Optional DATA_BUF_SEQ_REPLAY_EN adds cfg_replay to drain each tile cfg_replay+1 times.
module data_buf_seq
  import bmac_buf_pkg::*;
#(
  parameter  int ROWS   = `ROW_CNT,
  parameter  int MAC_BW = `MAC_BW,
  localparam int AW     = calc_aw(ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef DATA_BUF_SEQ_REPLAY_EN
  input  logic [REP_W-1:0]  cfg_replay,
`endif
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MAC_BW-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              buf_wr_en,
  output logic [AW-1:0]     buf_wr_addr,
  output logic [MAC_BW-1:0] buf_wr_data,
  output logic              buf_rd_en,
  output logic [AW-1:0]     buf_rd_addr,
  output logic              busy,
  output logic              done
);

  buf_seq_state_t state_reg;
  logic           done_reg;

  logic           in_fill;
  logic           in_drain;
  logic           wr_inc;
  logic           rd_inc;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           wr_last;
  logic           rd_last;

`ifdef DATA_BUF_SEQ_REPLAY_EN
  logic [REP_W-1:0] rep_cnt_reg;
  logic [REP_W-1:0] rep_max_reg;
`endif

  assign in_fill  = (state_reg == FILL);
  assign in_drain = (state_reg == DRAIN);

  // Handshake qualifiers feed only the pointers and the FSM, never the valid/ready outputs.
  assign wr_inc = in_fill & in_valid;
  assign rd_inc = in_drain & out_ready;

  row_ptr_cnt #(.MAX(ROWS - 1), .AW(AW)) u_wr_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (wr_inc),
    .clr  (flush),
    .ptr  (wr_ptr),
    .last (wr_last)
  );

  row_ptr_cnt #(.MAX(ROWS - 1), .AW(AW)) u_rd_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (rd_inc),
    .clr  (flush),
    .ptr  (rd_ptr),
    .last (rd_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      done_reg    <= 1'b0;
`ifdef DATA_BUF_SEQ_REPLAY_EN
      rep_cnt_reg <= '0;
      rep_max_reg <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (flush) begin
        state_reg   <= IDLE;
`ifdef DATA_BUF_SEQ_REPLAY_EN
        rep_cnt_reg <= '0;
`endif
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              state_reg   <= FILL;
`ifdef DATA_BUF_SEQ_REPLAY_EN
              rep_max_reg <= cfg_replay;
              rep_cnt_reg <= '0;
`endif
            end
          end
          FILL: begin
            if (wr_inc && wr_last) begin
              state_reg <= DRAIN;
            end
          end
          DRAIN: begin
            if (rd_inc && rd_last) begin
`ifdef DATA_BUF_SEQ_REPLAY_EN
              // rd_ptr has already wrapped to 0, so another pass starts without a bubble.
              if (rep_cnt_reg != rep_max_reg) begin
                rep_cnt_reg <= rep_cnt_reg + 1'b1;
              end else begin
                state_reg   <= IDLE;
                done_reg    <= 1'b1;
                rep_cnt_reg <= '0;
              end
`else
              state_reg <= IDLE;
              done_reg  <= 1'b1;
`endif
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign in_ready    = in_fill;
  assign buf_wr_en   = in_fill;
  assign buf_wr_addr = wr_ptr;
  assign buf_wr_data = in_data;
  assign out_valid   = in_drain;
  assign buf_rd_en   = in_drain;
  assign buf_rd_addr = rd_ptr;
  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;

endmodule

// File: tb/tb_data_buf_seq.sv
// Directed bench for data_buf_seq driving a data_buf: per-cycle vector table plus corner-case sequences.
`timescale 1ns/1ps
module tb_data_buf_seq;
  import bmac_buf_pkg::*;

  localparam int ROWS   = 4;
  localparam int MAC_BW = 16;
  localparam int AW     = 2;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              start     = 1'b0;
  logic              flush     = 1'b0;
  logic              in_valid  = 1'b0;
  logic              out_ready = 1'b0;
  logic [MAC_BW-1:0] in_data   = '0;
`ifdef DATA_BUF_SEQ_REPLAY_EN
  logic [REP_W-1:0]  cfg_replay = '0;
`endif

  logic              in_ready, out_valid, buf_wr_en, buf_rd_en, busy, done;
  logic [AW-1:0]     buf_wr_addr, buf_rd_addr;
  logic [MAC_BW-1:0] buf_wr_data, rd_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_buf_seq #(.ROWS(ROWS), .MAC_BW(MAC_BW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
`ifdef DATA_BUF_SEQ_REPLAY_EN
    .cfg_replay (cfg_replay),
`endif
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .buf_wr_en  (buf_wr_en),
    .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data),
    .buf_rd_en  (buf_rd_en),
    .buf_rd_addr(buf_rd_addr),
    .busy       (busy),
    .done       (done)
  );

  data_buf #(.ROWS(ROWS), .MAC_BW(MAC_BW), .AW(AW)) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (buf_wr_en),
    .wr_addr(buf_wr_addr),
    .iData  (buf_wr_data),
    .rd_en  (buf_rd_en),
    .rd_addr(buf_rd_addr),
    .oData  (rd_data)
  );

  typedef struct {
    logic        st, fl, iv;
    logic [15:0] id;
    logic        ordy;
    logic        e_busy, e_irdy, e_wchk;
    logic [1:0]  e_waddr;
    logic        e_ov;
    logic [1:0]  e_raddr;
    logic [15:0] e_odata;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic st, fl, iv, input logic [15:0] id, input logic ordy,
                             input logic bsy, irdy, wchk, input logic [1:0] waddr,
                             input logic ov, input logic [1:0] raddr, input logic [15:0] odata,
                             input logic dn);
    vec_t r;
    r.st = st; r.fl = fl; r.iv = iv; r.id = id; r.ordy = ordy;
    r.e_busy = bsy; r.e_irdy = irdy; r.e_wchk = wchk; r.e_waddr = waddr;
    r.e_ov = ov; r.e_raddr = raddr; r.e_odata = odata; r.e_done = dn;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller has the sequencer in FILL; writes ROWS rows starting at base.
  task automatic fill(input logic [15:0] base);
    for (int r = 0; r < ROWS; r++) begin
      in_valid = 1'b1;
      in_data  = base + 16'(r);
      #4;
      chk("fill_in_ready", in_ready, 1);
      chk("fill_wr_en", buf_wr_en, 1);
      chk("fill_wr_addr", buf_wr_addr, r);
      chk("fill_wr_data", buf_wr_data, base + 16'(r));
      $display("[TB] fill row %0d addr=%0d data=%h", r, buf_wr_addr, buf_wr_data);
      step();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Caller has the sequencer in DRAIN; consumes n rows with out_ready held high.
  task automatic drain(input logic [15:0] base, input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #4;
      chk("drain_out_valid", out_valid, 1);
      chk("drain_rd_en", buf_rd_en, 1);
      chk("drain_rd_addr", buf_rd_addr, i % ROWS);
      chk("drain_data", rd_data, base + 16'(i % ROWS));
      chk("drain_no_done", done, 0);
      $display("[TB] drain beat %0d addr=%0d data=%h", i, buf_rd_addr, rd_data);
      step();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    // Test 1: straight tile.
    vecs.push_back(v(1,0,0,16'h0000,0, 0,0,0,0, 0,0,16'h0000, 0));
    vecs.push_back(v(0,0,1,16'h1111,0, 1,1,1,0, 0,0,16'h0000, 0));
    vecs.push_back(v(0,0,1,16'h2222,0, 1,1,1,1, 0,0,16'h0000, 0));
    vecs.push_back(v(0,0,1,16'h3333,0, 1,1,1,2, 0,0,16'h0000, 0));
    vecs.push_back(v(0,0,1,16'h4444,0, 1,1,1,3, 0,0,16'h0000, 0));
    vecs.push_back(v(0,0,0,16'h0000,1, 1,0,0,0, 1,0,16'h1111, 0));
    vecs.push_back(v(0,0,0,16'h0000,1, 1,0,0,0, 1,1,16'h2222, 0));
    vecs.push_back(v(0,0,0,16'h0000,1, 1,0,0,0, 1,2,16'h3333, 0));
    vecs.push_back(v(0,0,0,16'h0000,1, 1,0,0,0, 1,3,16'h4444, 0));
    vecs.push_back(v(0,0,0,16'h0000,0, 0,0,0,0, 0,0,16'h0000, 1));
    vecs.push_back(v(0,0,0,16'h0000,0, 0,0,0,0, 0,0,16'h0000, 0));
    // Test 2: downstream backpressure 1,0,0,1,1,0,1.
    vecs.push_back(v(1,0,0,16'h0000,0, 0,0,0,0, 0,0,16'h0000, 0));
    vecs.push_back(v(0,0,1,16'hA001,0, 1,1,1,0, 0,0,16'h0000, 0));
    vecs.push_back(v(0,0,1,16'hA002,0, 1,1,1,1, 0,0,16'h0000, 0));
    vecs.push_back(v(0,0,1,16'hA003,0, 1,1,1,2, 0,0,16'h0000, 0));
    vecs.push_back(v(0,0,1,16'hA004,0, 1,1,1,3, 0,0,16'h0000, 0));
    vecs.push_back(v(0,0,0,16'h0000,1, 1,0,0,0, 1,0,16'hA001, 0));
    vecs.push_back(v(0,0,0,16'h0000,0, 1,0,0,0, 1,1,16'hA002, 0));
    vecs.push_back(v(0,0,0,16'h0000,0, 1,0,0,0, 1,1,16'hA002, 0));
    vecs.push_back(v(0,0,0,16'h0000,1, 1,0,0,0, 1,1,16'hA002, 0));
    vecs.push_back(v(0,0,0,16'h0000,1, 1,0,0,0, 1,2,16'hA003, 0));
    vecs.push_back(v(0,0,0,16'h0000,0, 1,0,0,0, 1,3,16'hA004, 0));
    vecs.push_back(v(0,0,0,16'h0000,1, 1,0,0,0, 1,3,16'hA004, 0));
    vecs.push_back(v(0,0,0,16'h0000,0, 0,0,0,0, 0,0,16'h0000, 1));
    // Test 3: upstream gaps 1,0,1,0,1,0,1; gap data must never reach the MAC.
    vecs.push_back(v(1,0,0,16'h0000,0, 0,0,0,0, 0,0,16'h0000, 0));
    vecs.push_back(v(0,0,1,16'hB001,0, 1,1,1,0, 0,0,16'h0000, 0));
    vecs.push_back(v(0,0,0,16'hDEAD,0, 1,1,0,1, 0,0,16'h0000, 0));
    vecs.push_back(v(0,0,1,16'hB002,0, 1,1,1,1, 0,0,16'h0000, 0));
    vecs.push_back(v(0,0,0,16'hDEAD,0, 1,1,0,2, 0,0,16'h0000, 0));
    vecs.push_back(v(0,0,1,16'hB003,0, 1,1,1,2, 0,0,16'h0000, 0));
    vecs.push_back(v(0,0,0,16'hDEAD,0, 1,1,0,3, 0,0,16'h0000, 0));
    vecs.push_back(v(0,0,1,16'hB004,0, 1,1,1,3, 0,0,16'h0000, 0));
    vecs.push_back(v(0,0,0,16'h0000,1, 1,0,0,0, 1,0,16'hB001, 0));
    vecs.push_back(v(0,0,0,16'h0000,1, 1,0,0,0, 1,1,16'hB002, 0));
    vecs.push_back(v(0,0,0,16'h0000,1, 1,0,0,0, 1,2,16'hB003, 0));
    vecs.push_back(v(0,0,0,16'h0000,1, 1,0,0,0, 1,3,16'hB004, 0));
    vecs.push_back(v(0,0,0,16'h0000,0, 0,0,0,0, 0,0,16'h0000, 1));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wr_en", buf_wr_en, 0);
    chk("rst_rd_en", buf_rd_en, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_addr", buf_wr_addr, 0);
    chk("rst_rd_addr", buf_rd_addr, 0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      start = vecs[i].st; flush = vecs[i].fl; in_valid = vecs[i].iv;
      in_data = vecs[i].id; out_ready = vecs[i].ordy;
      #4;
      chk("vec_busy", busy, vecs[i].e_busy);
      chk("vec_in_ready", in_ready, vecs[i].e_irdy);
      chk("vec_out_valid", out_valid, vecs[i].e_ov);
      chk("vec_rd_en", buf_rd_en, vecs[i].e_ov);
      chk("vec_done", done, vecs[i].e_done);
      if (vecs[i].e_irdy) chk("vec_wr_addr", buf_wr_addr, vecs[i].e_waddr);
      if (vecs[i].e_wchk) begin
        chk("vec_wr_en", buf_wr_en, 1);
        chk("vec_wr_data", buf_wr_data, vecs[i].id);
      end
      if (vecs[i].e_ov) begin
        chk("vec_rd_addr", buf_rd_addr, vecs[i].e_raddr);
        chk("vec_rd_data", rd_data, vecs[i].e_odata);
      end
      $display("[TB] vec %0d busy=%0b irdy=%0b waddr=%0d ov=%0b raddr=%0d data=%h done=%0b",
               i, busy, in_ready, buf_wr_addr, out_valid, buf_rd_addr, rd_data, done);
      step();
    end
    start = 0; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;

    // Test 4: flush at rd_addr=2 aborts without done; next tile refills from row 0.
    start = 1'b1; step(); start = 1'b0;
    fill(16'hC001);
    drain(16'hC001, 2);
    out_ready = 1'b1; flush = 1'b1;
    #4;
    chk("flush_rd_addr", buf_rd_addr, 2);
    $display("[TB] flush at addr=%0d", buf_rd_addr);
    step();
    flush = 1'b0; out_ready = 1'b0;
    #4;
    chk("flush_busy", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_no_done", done, 0);
    step();
    #4;
    chk("flush_no_late_done", done, 0);
    $display("[TB] post-flush busy=%0b done=%0b", busy, done);
    start = 1'b1; step(); start = 1'b0;
    fill(16'hD001);
    drain(16'hD001, ROWS);
    #4;
    chk("refill_done", done, 1);
    $display("[TB] refill done=%0b", done);
    step();

    // Test 5: start held through FILL/DRAIN is ignored; start in the done cycle is accepted.
    start = 1'b1; step();
    fill(16'hE001);
    drain(16'hE001, ROWS);
    #4;
    chk("busy_start_done", done, 1);
    chk("busy_start_idle", busy, 0);
    step();
    start = 1'b0;
    #4;
    chk("done_start_fill", in_ready, 1);
    chk("done_start_busy", busy, 1);
    chk("done_start_waddr", buf_wr_addr, 0);
    $display("[TB] start-in-done busy=%0b irdy=%0b", busy, in_ready);
    flush = 1'b1; step(); flush = 1'b0;
    #4;
    chk("fill_flush_busy", busy, 0);
    chk("fill_flush_in_ready", in_ready, 0);
    step();

`ifdef DATA_BUF_SEQ_REPLAY_EN
    // Test 6: three back-to-back passes, one done.
    cfg_replay = 4'd2;
    start = 1'b1; step(); start = 1'b0;
    cfg_replay = 4'd0;
    fill(16'hF001);
    drain(16'hF001, 3 * ROWS);
    #4;
    chk("replay_done", done, 1);
    chk("replay_idle", busy, 0);
    $display("[TB] replay done=%0b", done);
    step();
    #4;
    chk("replay_single_done", done, 0);
    step();
`endif

    // Asynchronous reset mid-drain clears everything immediately.
    start = 1'b1; step(); start = 1'b0;
    fill(16'h9001);
    drain(16'h9001, 2);
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_rd_en", buf_rd_en, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_wr_en", buf_wr_en, 0);
    chk("arst_rd_addr", buf_rd_addr, 0);
    chk("arst_done", done, 0);
    $display("[TB] async reset busy=%0b ov=%0b", busy, out_valid);
    out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    #4;
    chk("arst_release_idle", busy, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
